// File: rtl/stopwatch_match_unit_if.sv
// Bus bundle for stopwatch_match_unit: count feed, compare-register writes,
// per-channel arm/clear, and the registered match outputs.
interface stopwatch_match_unit_if #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    count;
    logic                count_valid;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [WIDTH-1:0]    wr_data;
    logic [CHANNELS-1:0] arm;
    logic [CHANNELS-1:0] clr;
    logic [CHANNELS-1:0] armed;
    logic [CHANNELS-1:0] match_flag;
    logic                match_pulse;
    logic [SEL_W-1:0]    match_ch;

    modport master (
        output count, count_valid, wr_en, wr_sel, wr_data, arm, clr,
        input  armed, match_flag, match_pulse, match_ch
    );

    modport slave (
        input  count, count_valid, wr_en, wr_sel, wr_data, arm, clr,
        output armed, match_flag, match_pulse, match_ch
    );
endinterface

// File: rtl/stopwatch_match_unit.sv
// Multi-channel count-match unit: CHANNELS programmable compare registers, each with
// an IDLE/ARMED/FIRED machine. Define MATCH_GE_EN to fire on count >= cmp instead of ==.
module stopwatch_match_unit #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stopwatch_match_unit_if.slave  bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [WIDTH-1:0]    cmp_q   [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] fire;
    logic [CHANNELS-1:0] armed_q;
    logic [CHANNELS-1:0] flag_q;
    logic                pulse_d, pulse_q;
    logic [SEL_W-1:0]    ch_d, ch_q;

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        pulse_d = 1'b0;
        ch_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i]  = bus.wr_en && (bus.wr_sel == SEL_W'(i));
`ifdef MATCH_GE_EN
            hit[i]     = (bus.count >= cmp_q[i]);
`else
            hit[i]     = (bus.count == cmp_q[i]);
`endif
            state_d[i] = state_q[i];
            // Per-channel priority: write-disarm > clr > match > arm.
            unique case (state_q[i])
                IDLE: begin
                    if (!wr_hit[i] && !bus.clr[i] && bus.arm[i]) state_d[i] = ARMED;
                end
                ARMED: begin
                    if (wr_hit[i] || bus.clr[i])           state_d[i] = IDLE;
                    else if (bus.count_valid && hit[i])    state_d[i] = FIRED;
                end
                FIRED: begin
                    if (wr_hit[i] || bus.clr[i])           state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
            fire[i] = (state_q[i] == ARMED) && (state_d[i] == FIRED);
        end
        pulse_d = |fire;
        // Scan downwards so the lowest firing index is the last one written.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fire[i]) ch_d = SEL_W'(i);
        end
    end

    // NOTE: the compare registers are a small flop array, not RAM, and are reset
    // because a channel armed straight after reset must compare against 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cmp_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
            armed_q <= '0;
            flag_q  <= '0;
            pulse_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // flop samples values from before this edge.
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) cmp_q[i] <= bus.wr_data;
                state_q[i] <= state_d[i];
                armed_q[i] <= (state_d[i] == ARMED);
                flag_q[i]  <= (state_d[i] == FIRED);
            end
            pulse_q <= pulse_d;
            ch_q    <= ch_d;
        end
    end

    assign bus.armed       = armed_q;
    assign bus.match_flag  = flag_q;
    assign bus.match_pulse = pulse_q;
    assign bus.match_ch    = ch_q;
endmodule

// File: tb/tb_stopwatch_match_unit.sv
// Scoreboard bench for stopwatch_match_unit: stimulus pushes expected match events,
// a negedge monitor pops and compares them whenever match_pulse is seen.
module tb_stopwatch_match_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_match_unit_if #(.WIDTH(19), .CHANNELS(4)) bus ();
    stopwatch_match_unit_if #(.WIDTH(19), .CHANNELS(3)) bus3 ();

    stopwatch_match_unit #(.WIDTH(19), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    stopwatch_match_unit #(.WIDTH(19), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    typedef struct {
        logic [1:0] ch;
        logic [3:0] flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [18:0] data);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_arm(input logic [3:0] mask);
        bus.arm = mask;
        cycle();
        bus.arm = '0;
    endtask

    task automatic do_clr(input logic [3:0] mask);
        bus.clr = mask;
        cycle();
        bus.clr = '0;
    endtask

    task automatic tick(input logic [18:0] c, input logic v);
        bus.count = c; bus.count_valid = v;
        cycle();
        bus.count_valid = 1'b0;
    endtask

    task automatic expect_fire(input logic [1:0] ch, input logic [3:0] flags);
        exp_t e;
        e.ch = ch; e.flags = flags;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse on the 4-channel unit must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && bus.match_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(bus.match_ch), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_match_ch", 32'(bus.match_ch), 32'(e.ch));
                check("sb_match_flag", 32'(bus.match_flag), 32'(e.flags));
            end
        end
    end

    initial begin
        bus.count = '0; bus.count_valid = 1'b0; bus.wr_en = 1'b0; bus.wr_sel = '0;
        bus.wr_data = '0; bus.arm = '0; bus.clr = '0;
        bus3.count = '0; bus3.count_valid = 1'b0; bus3.wr_en = 1'b0; bus3.wr_sel = '0;
        bus3.wr_data = '0; bus3.arm = '0; bus3.clr = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_armed", 32'(bus.armed), 32'h0);
        check("rst_flag", 32'(bus.match_flag), 32'h0);
        check("rst_pulse", 32'(bus.match_pulse), 32'h0);
        check("rst_ch", 32'(bus.match_ch), 32'h0);
        rst_n = 1'b1;
        cycle();

        // Basic match on channel 2
        wr(2'd2, 19'd1234);
        do_arm(4'b0100);
        check("basic_armed", 32'(bus.armed), 32'h4);
        for (int c = 1230; c <= 1236; c++) begin
            if (c == 1234) expect_fire(2'd2, 4'b0100);
            tick(19'(c), 1'b1);
            if (c == 1234) check("basic_flag", 32'(bus.match_flag), 32'h4);
            if (c == 1235) check("basic_pulse_one_cycle", 32'(bus.match_pulse), 32'h0);
        end
        check("basic_flag_held", 32'(bus.match_flag), 32'h4);
        check("basic_armed_after_fire", 32'(bus.armed), 32'h0);
        do_clr(4'b0100);
        check("basic_flag_clr", 32'(bus.match_flag), 32'h0);

        // Simultaneous fire on channels 0 and 3
        wr(2'd0, 19'd500);
        wr(2'd3, 19'd500);
        do_arm(4'b1001);
        expect_fire(2'd0, 4'b1001);
        tick(19'd500, 1'b1);
        check("simul_flag", 32'(bus.match_flag), 32'h9);
        cycle();
        check("simul_pulse_single", 32'(bus.match_pulse), 32'h0);
        do_clr(4'b1001);

        // clr in the matching cycle beats the match
        wr(2'd1, 19'd77);
        do_arm(4'b0010);
        bus.clr = 4'b0010;
        tick(19'd77, 1'b1);
        bus.clr = '0;
        check("prio_clr_flag", 32'(bus.match_flag), 32'h0);
        check("prio_clr_pulse", 32'(bus.match_pulse), 32'h0);
        check("prio_clr_armed", 32'(bus.armed), 32'h0);
        // Rewriting an armed channel disarms it
        do_arm(4'b0010);
        check("prio_rearm", 32'(bus.armed), 32'h2);
        wr(2'd1, 19'd77);
        check("prio_write_disarm", 32'(bus.armed), 32'h0);
        tick(19'd77, 1'b1);
        check("prio_no_fire_idle", 32'(bus.match_flag), 32'h0);

        // Skipped compare value
        wr(2'd0, 19'd100);
        do_arm(4'b0001);
        tick(19'd99, 1'b1);
`ifdef MATCH_GE_EN
        expect_fire(2'd0, 4'b0001);
        tick(19'd101, 1'b1);
        check("skip_ge_fire", 32'(bus.match_flag), 32'h1);
`else
        tick(19'd101, 1'b1);
        check("skip_eq_no_fire", 32'(bus.match_flag), 32'h0);
        check("skip_eq_still_armed", 32'(bus.armed), 32'h1);
`endif
        do_clr(4'b0001);

        // Full-width compare and wrap
        wr(2'd3, 19'h7FFFF);
        do_arm(4'b1000);
        tick(19'h7FFFE, 1'b1);
        check("wrap_no_early", 32'(bus.match_flag), 32'h0);
        expect_fire(2'd3, 4'b1000);
        tick(19'h7FFFF, 1'b1);
        check("wrap_fire", 32'(bus.match_flag), 32'h8);
        tick(19'h00000, 1'b1);
        tick(19'h00001, 1'b1);
        check("wrap_flag_held", 32'(bus.match_flag), 32'h8);
        do_clr(4'b1000);

        // Asynchronous reset with channel 1 FIRED
        wr(2'd1, 19'd42);
        do_arm(4'b0010);
        expect_fire(2'd1, 4'b0010);
        tick(19'd42, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_flag", 32'(bus.match_flag), 32'h0);
        check("async_rst_pulse", 32'(bus.match_pulse), 32'h0);
        check("async_rst_armed", 32'(bus.armed), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        // cmp returned to 0: channel 0 fires on count 0
        do_arm(4'b0001);
        expect_fire(2'd0, 4'b0001);
        tick(19'd0, 1'b1);
        check("post_rst_cmp0_fire", 32'(bus.match_flag), 32'h1);
        do_clr(4'b0001);

        // Out-of-range write on a 3-channel unit changes nothing
        bus3.wr_en = 1'b1; bus3.wr_sel = 2'd3; bus3.wr_data = 19'h55;
        bus3.arm = 3'b111;
        cycle();
        bus3.wr_en = 1'b0; bus3.arm = '0;
        check("oob_armed", 32'(bus3.armed), 32'h7);
        bus3.count = 19'd0; bus3.count_valid = 1'b1;
        cycle();
        bus3.count_valid = 1'b0;
        check("oob_flags", 32'(bus3.match_flag), 32'h7);
        check("oob_pulse", 32'(bus3.match_pulse), 32'h1);
        check("oob_ch", 32'(bus3.match_ch), 32'h0);

        cycle(); cycle();
        check("sb_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_match_unit.md
# stopwatch_match_unit

Parametrised multi-channel count-match block for the stopwatch datapath. It replaces the single fixed-width equality compare with CHANNELS programmable compare registers, each with its own arm/fire state machine. Each channel watches the running centisecond count and raises a sticky, registered match flag plus a one-cycle event pulse. It sits between the stopwatch counter and the alarm/lap display logic.

## Interface
- WIDTH, 19, bit width of count and compare values (19 bits = centisecond count up to 87 min)
- CHANNELS, 4, number of independent compare channels, 1..16
- SEL_W, $clog2(CHANNELS) (min 1), localparam, width of channel select/index
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- count  in  WIDTH  running stopwatch count
- count_valid  in  1  count updated this cycle; compares evaluated only when high
- wr_en  in  1  write wr_data into compare register wr_sel
- wr_sel  in  SEL_W  channel written; values >= CHANNELS ignored
- wr_data  in  WIDTH  compare value
- arm  in  CHANNELS  per-channel arm request (level sampled each cycle)
- clr  in  CHANNELS  per-channel clear of flag and return to IDLE
- armed  out  CHANNELS  channel in ARMED state
- match_flag  out  CHANNELS  sticky per-channel match (channel in FIRED)
- match_pulse  out  1  high one cycle when any channel entered FIRED
- match_ch  out  SEL_W  lowest-index channel that entered FIRED in that cycle; 0 when match_pulse low

## Operation
- Per channel: registers cmp[WIDTH-1:0] and 2-bit state IDLE, ARMED, FIRED.
- IDLE -> ARMED: arm[i]=1 and no clr[i]/write to i this cycle.
- ARMED -> FIRED: count_valid=1 and hit[i]; hit is count==cmp[i] (see Configuration).
- FIRED -> IDLE: clr[i]=1. arm[i] in FIRED ignored.
- ARMED -> IDLE: clr[i]=1, or wr_en with wr_sel==i (rewriting a compare value always disarms).
- Priority per channel, per cycle: write-disarm > clr > match > arm. A match and clr in the same cycle: clr wins, flag not set, no pulse.
- Write while IDLE/FIRED: cmp updated; FIRED channel returns to IDLE (flag drops).
- Compare uses cmp value registered before the edge; a write in cycle n is compared from cycle n+1.
- Multiple channels firing in one cycle: all flags set; match_pulse single cycle; match_ch = lowest index.
- count_valid low: no state transitions due to match; other transitions still occur.
- Equality is full-width; all WIDTH bits compared, no masking.

## Timing
- Reset (rst_n low, asynchronous): cmp all 0, all channels IDLE, armed=0, match_flag=0, match_pulse=0, match_ch=0. Deassertion synchronised externally.
- Reset mid-operation: all state cleared immediately; pending matches lost.
- arm sampled at edge n -> armed[i]=1 after edge n.
- Match latency 1 cycle: count_valid and hit at edge n -> match_flag[i], match_pulse, match_ch valid after edge n; match_pulse low after edge n+1 unless another channel fires.
- clr at edge n -> match_flag[i]=0 after edge n.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MATCH_GE_EN defined: hit[i] = (count >= cmp[i]), unsigned; an armed channel fires even if count skips past cmp, and a channel armed with count already >= cmp fires on the next count_valid.
- MATCH_GE_EN undefined: hit[i] = (count == cmp[i]) only; a skipped value never fires.

## Test plan
- Reset: drive rst_n=0 mid-run with ch1 FIRED -> all outputs 0 immediately, cmp reads back 0 behaviour (arm ch0, count=0 with valid -> fires).
- Basic match: write ch2=1234, arm ch2, step count 1230..1236 with count_valid -> match_flag[2] rises one cycle after count=1234, match_pulse one cycle, match_ch=2, flag held until clr[2].
- Simultaneous: ch0=500, ch3=500 both armed, count=500 -> match_flag=4'b1001, single match_pulse, match_ch=0.
- Priority: ch1 armed at 77, apply clr[1] in the cycle count=77 -> no flag, no pulse, ch1 IDLE; rewrite ch1 while ARMED -> armed[1]=0.
- Skip: ch0=100 armed, count goes 99 -> 101 -> without MATCH_GE_EN no fire; with MATCH_GE_EN fires after 101.
- Wrap/width: WIDTH=19, cmp=19'h7FFFF, count reaches 19'h7FFFF then wraps to 0 -> fires exactly once at 7FFFF; wr_sel>=CHANNELS (CHANNELS=3, wr_sel=3) -> no register changes.
